// File: rtl/chacha_pkg.sv
// Shared ChaCha constants, state types and quarter-round index tables.
package chacha_pkg;

    typedef logic [15:0][31:0] chacha_state_t;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} chacha_fsm_t;

    // "expand 32-byte k"
    localparam logic [31:0] SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

    // Word indices (a,b,c,d) for the four quarter-rounds of a column / diagonal half-round
    localparam logic [3:0] COL_IDX [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };
    localparam logic [3:0] DIAG_IDX [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_qr_comb.sv
// Purely combinational ChaCha quarter round.
module chacha_qr_comb
    import chacha_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [31:0] a1, b1, c1, d1, a2, b2, c2, d2;

    // add / xor / rotate chain, all sums mod 2^32
    always_comb begin
        a1 = a + b;
        d1 = rotl32(d ^ a1, 16);
        c1 = c + d1;
        b1 = rotl32(b ^ c1, 12);
        a2 = a1 + b1;
        d2 = rotl32(d1 ^ a2, 8);
        c2 = c1 + d2;
        b2 = rotl32(b1 ^ c2, 7);
        a_o = a2;
        b_o = b2;
        c_o = c2;
        d_o = d2;
    end

endmodule

// File: rtl/chacha_block_engine.sv
// Iterative ChaCha block core: one half-round per cycle, feed-forward,
// multi-block streaming with auto-incrementing block counter.
module chacha_block_engine
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20,
    parameter int NBLK_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [255:0]      key,
    input  logic [95:0]       nonce,
    input  logic [31:0]       counter,
    input  logic [NBLK_W-1:0] nblocks,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [511:0]      keystream,
    output logic [31:0]       out_ctr,
    output logic              out_last,
    output logic              ctr_wrap
);

    if ((ROUNDS % 2) != 0 || ROUNDS < 2 || ROUNDS > 20) begin : g_bad_rounds
        $error("chacha_block_engine: ROUNDS must be even and within 2..20");
    end

    chacha_fsm_t       state, state_n;
    logic [4:0]        rnd;
    chacha_state_t     work, init, req_state, rnd_state, reload, ks_q;
    logic [NBLK_W-1:0] remaining;
    logic [3:0]        qi [4][4];
    logic [31:0]       qa_o [4], qb_o [4], qc_o [4], qd_o [4];
    logic              accept, last_rnd;

    // Ready drops combinationally with reset so nothing is accepted mid-reset
    assign in_ready  = (state == IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign last_rnd  = (rnd == 5'(ROUNDS - 1));
    assign keystream = ks_q;

    // Initial block state from the request inputs
    always_comb begin
        req_state = '0;
        for (int i = 0; i < 4; i++) req_state[i] = SIGMA[i];
        for (int i = 0; i < 8; i++) req_state[4+i] = key[32*i +: 32];
        req_state[12] = counter;
        for (int j = 0; j < 3; j++) req_state[13+j] = nonce[32*j +: 32];
    end

    // Next block's starting state: same key/nonce, counter + 1
    always_comb begin
        reload     = init;
        reload[12] = init[12] + 32'd1;
    end

    // Odd rounds use diagonal wiring, even rounds column wiring
    always_comb begin
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++)
                qi[g][k] = rnd[0] ? DIAG_IDX[g][k] : COL_IDX[g][k];
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        chacha_qr_comb u_qr (
            .a   (work[qi[g][0]]),
            .b   (work[qi[g][1]]),
            .c   (work[qi[g][2]]),
            .d   (work[qi[g][3]]),
            .a_o (qa_o[g]),
            .b_o (qb_o[g]),
            .c_o (qc_o[g]),
            .d_o (qd_o[g])
        );
    end

    // Scatter quarter-round results back to their state words
    always_comb begin
        rnd_state = work;
        for (int g = 0; g < 4; g++) begin
            rnd_state[qi[g][0]] = qa_o[g];
            rnd_state[qi[g][1]] = qb_o[g];
            rnd_state[qi[g][2]] = qc_o[g];
            rnd_state[qi[g][3]] = qd_o[g];
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // FSM next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept)    state_n = ROUND;
            ROUND:   if (last_rnd)  state_n = FINAL;
            FINAL:                  state_n = HOLD;
            HOLD:    if (out_ready) state_n = out_last ? IDLE : ROUND;
            default:                state_n = IDLE;
        endcase
    end

    // Datapath: load, iterate, feed-forward, hold and reload for the next block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work      <= '0;
            init      <= '0;
            remaining <= '0;
            rnd       <= '0;
            ks_q      <= '0;
            out_ctr   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            ctr_wrap  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    work      <= req_state;
                    init      <= req_state;
                    remaining <= (nblocks == '0) ? NBLK_W'(1) : nblocks;
                    ctr_wrap  <= 1'b0;
                    rnd       <= '0;
                end
                ROUND: begin
                    work <= rnd_state;
                    rnd  <= rnd + 5'd1;
                end
                FINAL: begin
                    for (int i = 0; i < 16; i++) ks_q[i] <= work[i] + init[i];
                    out_ctr   <= init[12];
                    out_last  <= (remaining == NBLK_W'(1));
                    out_valid <= 1'b1;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (!out_last) begin
                        remaining <= remaining - NBLK_W'(1);
                        init[12]  <= reload[12];
                        work      <= reload;
                        rnd       <= '0;
                        if (init[12] == 32'hFFFF_FFFF) ctr_wrap <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_engine.sv
// Scoreboard bench for chacha_block_engine (ROUNDS=20 main instance, ROUNDS=8 side instance).
module tb_chacha_block_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready, out_last, ctr_wrap;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter, out_ctr;
    logic [7:0]   nblocks;
    logic [511:0] keystream;

    logic         in_valid8, in_ready8, out_valid8, out_last8, ctr_wrap8;
    logic         out_ready8 = 1'b1;
    logic [31:0]  out_ctr8;
    logic [511:0] keystream8;

    logic [31:0]  qa, qb, qc, qd, qa_o, qb_o, qc_o, qd_o;

    always #5 clk = ~clk;

    chacha_block_engine #(.ROUNDS(20), .NBLK_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .nonce(nonce), .counter(counter), .nblocks(nblocks),
        .out_valid(out_valid), .out_ready(out_ready), .keystream(keystream),
        .out_ctr(out_ctr), .out_last(out_last), .ctr_wrap(ctr_wrap)
    );

    chacha_block_engine #(.ROUNDS(8), .NBLK_W(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .key(key), .nonce(nonce), .counter(counter), .nblocks(nblocks),
        .out_valid(out_valid8), .out_ready(out_ready8), .keystream(keystream8),
        .out_ctr(out_ctr8), .out_last(out_last8), .ctr_wrap(ctr_wrap8)
    );

    chacha_qr_comb u_qr (
        .a(qa), .b(qb), .c(qc), .d(qd),
        .a_o(qa_o), .b_o(qb_o), .c_o(qc_o), .d_o(qd_o)
    );

    typedef struct {
        logic [511:0] ks;
        logic [31:0]  ctr;
        logic         last;
        logic         wrap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   bp_mode = 0;  // 0: always ready, 1: random, 2: stall 5 cycles per block

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr_ref(input logic [31:0] a, b, c, d);
        a += b; d ^= a; d = rl(d, 16);
        c += d; b ^= c; b = rl(b, 12);
        a += b; d ^= a; d = rl(d, 8);
        c += d; b ^= c; b = rl(b, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] ctr, input int rounds);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = ctr;
        for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
        x = s;
        for (int dr = 0; dr < rounds / 2; dr++) begin
            {x[0], x[4], x[8],  x[12]} = qr_ref(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr_ref(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr_ref(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr_ref(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr_ref(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr_ref(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr_ref(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr_ref(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    task automatic push_expected(input logic [255:0] k, input logic [95:0] n,
                                 input logic [31:0] c, input logic [7:0] nb);
        int   cnt;
        exp_t e;
        cnt = (nb == 8'd0) ? 1 : int'(nb);
        for (int b = 0; b < cnt; b++) begin
            e.ctr  = c + 32'(b);
            e.ks   = ref_block(k, n, e.ctr, 20);
            e.last = (b == cnt - 1);
            e.wrap = ({1'b0, c} + 33'(b)) > 33'h0_FFFF_FFFF;
            sb.push_back(e);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- out_ready driver ----------------
    initial begin
        int stall = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (!out_valid) begin
                        out_ready = 1'b0;
                        stall = 0;
                    end else if (stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [511:0] p_ks;
        logic [31:0]  p_ctr;
        logic         p_last, p_wrap, p_stall;
        exp_t         e;
        p_stall = 1'b0;
        p_ks = '0; p_ctr = '0; p_last = 1'b0; p_wrap = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_stall = 1'b0;
            end else begin
                if (p_stall) begin
                    chk("stall_valid", out_valid, 1'b1);
                    chk("stall_ks", keystream, p_ks);
                    chk("stall_ctr", out_ctr, p_ctr);
                    chk("stall_last", out_last, p_last);
                    chk("stall_wrap", ctr_wrap, p_wrap);
                end
                if (out_valid) chk("busy_in_ready", in_ready, 1'b0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_block: got ctr %0h expected no block", out_ctr);
                    end else begin
                        e = sb.pop_front();
                        chk("blk_ks", keystream, e.ks);
                        chk("blk_ctr", out_ctr, e.ctr);
                        chk("blk_last", out_last, e.last);
                        chk("blk_wrap", ctr_wrap, e.wrap);
                    end
                end
                p_stall = out_valid && !out_ready;
                p_ks = keystream; p_ctr = out_ctr; p_last = out_last; p_wrap = ctr_wrap;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [255:0] k, input logic [95:0] n,
                         input logic [31:0] c, input logic [7:0] nb);
        int t = 0;
        @(negedge clk);
        key = k; nonce = n; counter = c; nblocks = nb; in_valid = 1'b1;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        push_expected(k, n, c, nb);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [255:0] gk, k2;
        logic [95:0]  gn, n2;
        int           n, busy;
        bit           seen;

        reset = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0;
        key = '0; nonce = '0; counter = '0; nblocks = '0;
        for (int i = 0; i < 32; i++) gk[8*i +: 8] = 8'(i);
        gn = {32'h0000_0000, 32'h4a00_0000, 32'h0900_0000};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_keystream", keystream, '0);
        chk("rst_out_ctr", out_ctr, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_ctr_wrap", ctr_wrap, 1'b0);
        reset = 1'b0;
        #1 chk("rel_in_ready", in_ready, 1'b1);

        // quarter-round unit vector
        qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
        #1;
        chk("qr_a", qa_o, 32'hea2a92f4);
        chk("qr_b", qb_o, 32'hcb1cf8ce);
        chk("qr_c", qc_o, 32'h4581472e);
        chk("qr_d", qd_o, 32'h5881c4bb);

        // golden block vector + latency (accepting edge counted as edge 1)
        bp_mode = 0;
        issue(gk, gn, 32'd1, 8'd1);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency20", n, 22);
        @(negedge clk);
        chk("gold_w0", keystream[31:0], 32'he4e7f110);
        chk("gold_w1", keystream[63:32], 32'h15593bd1);
        chk("gold_w15", keystream[511:480], 32'h4e3c50a2);
        chk("gold_ctr", out_ctr, 32'd1);
        chk("gold_last", out_last, 1'b1);
        drain();

        // multi-block with wrap and backpressure
        bp_mode = 2;
        issue(rand256(), {$urandom, $urandom, $urandom}, 32'hFFFF_FFFE, 8'd3);
        drain();
        chk("multi_idle_ready", in_ready, 1'b1);
        chk("wrap_sticky_idle", ctr_wrap, 1'b1);

        // nblocks=0 -> one block; in_valid while busy is ignored
        bp_mode = 0;
        k2 = rand256(); n2 = {$urandom, $urandom, $urandom};
        issue(rand256(), {$urandom, $urandom, $urandom}, $urandom, 8'd0);
        @(negedge clk);
        key = k2; nonce = n2; counter = 32'h1234_5678; nblocks = 8'd2; in_valid = 1'b1;
        busy = 0;
        while (!in_ready && busy < 200) begin
            @(negedge clk);
            busy++;
        end
        chk("busy_not_accepted", busy >= 21, 1'b1);
        chk("first_done_before_second", sb.size(), 0);
        @(posedge clk);
        push_expected(k2, n2, 32'h1234_5678, 8'd2);
        #1 in_valid = 1'b0;
        drain();

        // randomized requests under random backpressure
        bp_mode = 1;
        for (int r = 0; r < 8; r++) begin
            logic [31:0] c;
            c = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : $urandom;
            issue(rand256(), {$urandom, $urandom, $urandom}, c, 8'($urandom_range(0, 3)));
        end
        drain();

        // reset mid-ROUND
        bp_mode = 0;
        issue(rand256(), {$urandom, $urandom, $urandom}, $urandom, 8'd1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ks", keystream, '0);
        chk("mid_rst_ctr", out_ctr, '0);
        chk("mid_rst_last", out_last, 1'b0);
        chk("mid_rst_wrap", ctr_wrap, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 chk("mid_rel_in_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("no_block_after_reset", seen, 1'b0);

        // ROUNDS=8 instance on the golden vector
        @(negedge clk);
        chk("r8_ready", in_ready8, 1'b1);
        key = gk; nonce = gn; counter = 32'd1; nblocks = 8'd1; in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency8", n, 10);
        @(negedge clk);
        chk("r8_ks", keystream8, ref_block(gk, gn, 32'd1, 8));
        chk("r8_ctr", out_ctr8, 32'd1);
        chk("r8_last", out_last8, 1'b1);
        repeat (3) @(negedge clk);
        chk("r8_idle", in_ready8, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
